vxe_fifowx2w: RTL and testbench

VXE_FIFOWX2W -- requirements
Module: vxe_fifowx2w

---
 rtl/vxe_fifowx2w.sv | 67 ++++++
 tb/tb_vxe_fifowx2w.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/vxe_fifowx2w.sv
// vxe_fifowx2w: single-word write, dual-word show-ahead read FIFO.
// data_out presents the two oldest entries; rd pops one or two per cycle.
module vxe_fifowx2w #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH_POW2 = 2
) (
  input  logic                    clk,
  input  logic                    nrst,
  input  logic [DATA_WIDTH-1:0]   data_in,
  input  logic                    wr,
  output logic                    in_rdy,
  output logic [2*DATA_WIDTH-1:0] data_out,
  input  logic [1:0]              rd,
  output logic [1:0]              out_vld
);

  localparam int DEPTH = 1 << DEPTH_POW2;
  localparam int PW    = DEPTH_POW2;
  localparam int CW    = DEPTH_POW2 + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         rd_ptr;
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr_p1;
  logic [CW-1:0]         count;
  logic                  wr_acc;
  logic [1:0]            pops;

  // Status flags and pop count, all decoded from registered count only
  always_comb begin
    in_rdy     = (count < DEPTH_C);
    out_vld[0] = (count != '0);
    out_vld[1] = (count > CW'(1));
    wr_acc     = wr & in_rdy;
    pops       = {1'b0, rd[0] & out_vld[0]} + {1'b0, rd[0] & rd[1] & out_vld[1]};
    rd_ptr_p1  = rd_ptr + PW'(1);
  end

  // Show-ahead output: oldest entry low, second-oldest high
  always_comb begin
    data_out = {mem[rd_ptr_p1], mem[rd_ptr]};
  end

  // Storage write; contents intentionally survive reset
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr] <= data_in;
    end
  end

  // Pointer and occupancy update; write and pop may coincide
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      rd_ptr <= rd_ptr + PW'(pops);
      count  <= count + CW'(wr_acc) - CW'(pops);
    end
  end

endmodule

// File: tb/tb_vxe_fifowx2w.sv
// Directed testbench for vxe_fifowx2w (W=32, depth 4).
module tb_vxe_fifowx2w;

  logic        clk;
  logic        nrst;
  logic [31:0] data_in;
  logic        wr;
  logic        in_rdy;
  logic [63:0] data_out;
  logic [1:0]  rd;
  logic [1:0]  out_vld;

  int unsigned checks = 0;
  int unsigned passes = 0;

  vxe_fifowx2w #(.DATA_WIDTH(32), .DEPTH_POW2(2)) dut (
    .clk      (clk),
    .nrst     (nrst),
    .data_in  (data_in),
    .wr       (wr),
    .in_rdy   (in_rdy),
    .data_out (data_out),
    .rd       (rd),
    .out_vld  (out_vld)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, then settle before sampling/driving.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    nrst = 1'b1; wr = 1'b0; rd = 2'b00; data_in = '0;
    #1 nrst = 1'b0;
    #2;
    checks++; if (out_vld !== 2'b00) $display("FAIL reset_vld: got %b want 00", out_vld); else passes++;
    checks++; if (in_rdy !== 1'b1) $display("FAIL reset_rdy: got %b want 1", in_rdy); else passes++;
    step(); step();
    nrst = 1'b1;
    rd = 2'b11;
    step();
    rd = 2'b00;
    checks++; if (out_vld !== 2'b00) $display("FAIL reset_empty_pop_vld: got %b want 00", out_vld); else passes++;
    checks++; if (in_rdy !== 1'b1) $display("FAIL reset_empty_pop_rdy: got %b want 1", in_rdy); else passes++;
  endtask

  task automatic test_fill();
    for (int i = 0; i < 4; i++) begin
      data_in = 32'hBEEF0001 + 32'(i);
      wr = 1'b1;
      step();
    end
    wr = 1'b0;
    checks++; if (in_rdy !== 1'b0) $display("FAIL fill_rdy: got %b want 0", in_rdy); else passes++;
    checks++; if (out_vld !== 2'b11) $display("FAIL fill_vld: got %b want 11", out_vld); else passes++;
    checks++; if (data_out !== 64'hBEEF0002_BEEF0001) $display("FAIL fill_data: got %h want BEEF0002BEEF0001", data_out); else passes++;
    data_in = 32'hDEAD0005; wr = 1'b1;
    step();
    wr = 1'b0;
    checks++; if (in_rdy !== 1'b0) $display("FAIL fill_drop_rdy: got %b want 0", in_rdy); else passes++;
    checks++; if (data_out !== 64'hBEEF0002_BEEF0001) $display("FAIL fill_drop_data: got %h want BEEF0002BEEF0001", data_out); else passes++;
  endtask

  task automatic test_drain();
    rd = 2'b11;
    step();
    checks++; if (data_out !== 64'hBEEF0004_BEEF0003) $display("FAIL drain_data: got %h want BEEF0004BEEF0003", data_out); else passes++;
    checks++; if (in_rdy !== 1'b1) $display("FAIL drain_rdy: got %b want 1", in_rdy); else passes++;
    checks++; if (out_vld !== 2'b11) $display("FAIL drain_vld2: got %b want 11", out_vld); else passes++;
    step();
    rd = 2'b00;
    checks++; if (out_vld !== 2'b00) $display("FAIL drain_empty_vld: got %b want 00", out_vld); else passes++;
  endtask

  task automatic test_odd_count();
    for (int i = 1; i <= 3; i++) begin
      data_in = 32'(i); wr = 1'b1;
      step();
    end
    wr = 1'b0;
    rd = 2'b11;
    step();
    checks++; if (out_vld !== 2'b01) $display("FAIL odd_vld: got %b want 01", out_vld); else passes++;
    checks++; if (data_out[31:0] !== 32'h3) $display("FAIL odd_data: got %h want 00000003", data_out[31:0]); else passes++;
    rd = 2'b10;
    step();
    checks++; if (out_vld !== 2'b01) $display("FAIL odd_rd10_vld: got %b want 01", out_vld); else passes++;
    checks++; if (data_out[31:0] !== 32'h3) $display("FAIL odd_rd10_data: got %h want 00000003", data_out[31:0]); else passes++;
    rd = 2'b11;
    step();
    checks++; if (out_vld !== 2'b00) $display("FAIL odd_clip_vld: got %b want 00", out_vld); else passes++;
    rd = 2'b10;
    step();
    rd = 2'b00;
    checks++; if (out_vld !== 2'b00) $display("FAIL odd_rd10_empty_vld: got %b want 00", out_vld); else passes++;
  endtask

  // Read pointer sits at 3 here; one preload entry keeps count at 1 while streaming.
  task automatic test_wrap();
    data_in = 32'h9F; wr = 1'b1;
    step();
    for (int k = 0; k < 6; k++) begin
      data_in = 32'hA0 + 32'(k); wr = 1'b1; rd = 2'b01;
      step();
      checks++; if (out_vld !== 2'b01) $display("FAIL wrap_vld_%0d: got %b want 01", k, out_vld); else passes++;
      checks++; if (data_out[31:0] !== 32'hA0 + 32'(k)) $display("FAIL wrap_data_%0d: got %h want %h", k, data_out[31:0], 32'hA0 + 32'(k)); else passes++;
    end
    rd = 2'b00;
    for (int k = 0; k < 3; k++) begin
      data_in = 32'hB0 + 32'(k); wr = 1'b1;
      step();
    end
    wr = 1'b0;
    checks++; if (in_rdy !== 1'b0) $display("FAIL wrap_full_rdy: got %b want 0", in_rdy); else passes++;
    rd = 2'b10;
    step();
    checks++; if (data_out !== 64'h000000B0_000000A5) $display("FAIL wrap_rd10_data: got %h want 000000B0000000A5", data_out); else passes++;
    checks++; if (in_rdy !== 1'b0) $display("FAIL wrap_rd10_rdy: got %b want 0", in_rdy); else passes++;
    data_in = 32'hC0; wr = 1'b1; rd = 2'b11;
    step();
    wr = 1'b0;
    checks++; if (out_vld !== 2'b11) $display("FAIL wrap_fullpop_vld: got %b want 11", out_vld); else passes++;
    checks++; if (in_rdy !== 1'b1) $display("FAIL wrap_fullpop_rdy: got %b want 1", in_rdy); else passes++;
    checks++; if (data_out !== 64'h000000B2_000000B1) $display("FAIL wrap_fullpop_data: got %h want 000000B2000000B1", data_out); else passes++;
    step();
    rd = 2'b00;
    checks++; if (out_vld !== 2'b00) $display("FAIL wrap_drop_vld: got %b want 00", out_vld); else passes++;
  endtask

  task automatic test_reset_mid();
    data_in = 32'h11; wr = 1'b1;
    step();
    data_in = 32'h22;
    step();
    wr = 1'b0;
    checks++; if (out_vld !== 2'b11) $display("FAIL rstmid_pre_vld: got %b want 11", out_vld); else passes++;
    #2 nrst = 1'b0;
    #1;
    checks++; if (out_vld !== 2'b00) $display("FAIL rstmid_vld: got %b want 00", out_vld); else passes++;
    checks++; if (in_rdy !== 1'b1) $display("FAIL rstmid_rdy: got %b want 1", in_rdy); else passes++;
    step();
    nrst = 1'b1;
    data_in = 32'h55; wr = 1'b1;
    step();
    wr = 1'b0;
    checks++; if (out_vld !== 2'b01) $display("FAIL rstmid_after_vld: got %b want 01", out_vld); else passes++;
    checks++; if (data_out[31:0] !== 32'h55) $display("FAIL rstmid_after_data: got %h want 00000055", data_out[31:0]); else passes++;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_odd_count();
    test_wrap();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "timeout");
  end

endmodule
